otter_iobus_bridge: RTL and testbench

Parametrised memory-mapped I/O bridge between the OTTER core's memory stage and up to NUM_PORTS peripherals. It supersedes the single flat IOBUS_IN/IOBUS_OUT/IOBUS_WR/IOBUS_ADDR connection with the following:
- address decode to per-port selects;
- a request/ready handshake with each peripheral;
- read-data capture;
- an error response for unmapped addresses and hung peripherals.

Core-side accesses are single-outstanding. The control unit stalls on CPU_BUSY.

---
 rtl/otter_iobus_pkg.sv | 19 +
 rtl/otter_iobus_decode.sv | 35 +++
 rtl/otter_iobus_bridge.sv | 194 +++++++++++++++++++
 tb/tb_otter_iobus_bridge.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/otter_iobus_pkg.sv
// Shared types and defaults for the OTTER I/O bus bridge.
// OTTER_IOBUS_TIMEOUT_EN (in otter_iobus_bridge) enables the hung-peripheral timeout.
package otter_iobus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1100_0000;
  localparam int          DEF_SPAN_LOG2 = 8;
  localparam logic [31:0] ERR_RDATA     = 32'h0000_0000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/otter_iobus_decode.sv
// Combinational I/O window decoder: byte address -> {hit, port index, one-hot select}.
// Shared by the bridge and peripheral-side models so both agree on the map.
module otter_iobus_decode
  import otter_iobus_pkg::*;
#(
  parameter int                NUM_PORTS = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int                SPAN_LOG2 = DEF_SPAN_LOG2,
  localparam int               IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [ADDR_W-1:0]    addr,
  output logic                 hit,
  output logic [IDX_W-1:0]     index,
  output logic [NUM_PORTS-1:0] onehot
);

  logic [ADDR_W-1:0] off_s;
  logic [ADDR_W-1:0] page_s;

  assign off_s  = addr - BASE_ADDR;
  assign page_s = off_s >> SPAN_LOG2;
  // Below-base addresses wrap to huge offsets, so the >= test is needed as well.
  assign hit    = (addr >= BASE_ADDR) && (page_s < ADDR_W'(NUM_PORTS));
  assign index  = page_s[IDX_W-1:0];

  // Expand the index into a one-hot select, all zero on a miss.
  always_comb begin
    onehot = {NUM_PORTS{1'b0}};
    for (int k = 0; k < NUM_PORTS; k++) begin
      onehot[k] = hit && (index == IDX_W'(k));
    end
  end

endmodule

// File: rtl/otter_iobus_bridge.sv
// OTTER memory-stage to multi-port peripheral bridge with ready handshake and error response.
// Optional macro OTTER_IOBUS_TIMEOUT_EN adds a TIMEOUT_CYC cycle hung-peripheral timeout.
module otter_iobus_bridge
  import otter_iobus_pkg::*;
#(
  parameter int                NUM_PORTS   = 4,
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter int                SPAN_LOG2   = DEF_SPAN_LOG2,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CPU_REQ,
  input  logic                        CPU_WE,
  input  logic [ADDR_W-1:0]           CPU_ADDR,
  input  logic [DATA_W-1:0]           CPU_WDATA,
  output logic [DATA_W-1:0]           CPU_RDATA,
  output logic                        CPU_ACK,
  output logic                        CPU_ERR,
  output logic                        CPU_BUSY,
  output logic [NUM_PORTS-1:0]        IO_SEL,
  output logic                        IO_WR,
  output logic                        IO_RD,
  output logic [SPAN_LOG2-1:0]        IO_ADDR,
  output logic [DATA_W-1:0]           IO_WDATA,
  input  logic [NUM_PORTS*DATA_W-1:0] IO_RDATA,
  input  logic [NUM_PORTS-1:0]        IO_RDY
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  state_t                 state_r, state_n;
  logic                   we_r, we_n;
  logic [IDX_W-1:0]       idx_r, idx_n;
  logic [NUM_PORTS-1:0]   sel_r, sel_n;
  logic                   wr_r, wr_n, rd_r, rd_n;
  logic [SPAN_LOG2-1:0]   addr_r, addr_n;
  logic [DATA_W-1:0]      wdata_r, wdata_n, rdata_r, rdata_n;
  logic                   ack_r, ack_n, err_r, err_n, busy_r;
  logic                   hit_s;
  logic [IDX_W-1:0]       dec_idx_s;
  logic [NUM_PORTS-1:0]   dec_onehot_s;
  logic [SPAN_LOG2-1:0]   off_s;
`ifdef OTTER_IOBUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_r, cnt_n;
`endif

  otter_iobus_decode #(
    .NUM_PORTS (NUM_PORTS),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .SPAN_LOG2 (SPAN_LOG2)
  ) u_decode (
    .addr   (CPU_ADDR),
    .hit    (hit_s),
    .index  (dec_idx_s),
    .onehot (dec_onehot_s)
  );

  assign off_s = SPAN_LOG2'(CPU_ADDR - BASE_ADDR);

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_n = state_r;
    we_n    = we_r;
    idx_n   = idx_r;
    sel_n   = sel_r;
    wr_n    = wr_r;
    rd_n    = rd_r;
    addr_n  = addr_r;
    wdata_n = wdata_r;
    rdata_n = rdata_r;
    ack_n   = 1'b0;
    err_n   = 1'b0;
`ifdef OTTER_IOBUS_TIMEOUT_EN
    cnt_n   = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (CPU_REQ) begin
          we_n = CPU_WE;
          if (hit_s) begin
            state_n = ACCESS;
            idx_n   = dec_idx_s;
            sel_n   = dec_onehot_s;
            wr_n    = CPU_WE;
            rd_n    = !CPU_WE;
            addr_n  = off_s;
            wdata_n = CPU_WDATA;
`ifdef OTTER_IOBUS_TIMEOUT_EN
            cnt_n   = {CNT_W{1'b0}};
`endif
          end else begin
            state_n = RESP;
            ack_n   = 1'b1;
            err_n   = 1'b1;
            rdata_n = DATA_W'(ERR_RDATA);
          end
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        // Only the selected port's ready counts; a simultaneous timeout loses to it.
        if (IO_RDY[idx_r]) begin
          state_n = RESP;
          sel_n   = {NUM_PORTS{1'b0}};
          wr_n    = 1'b0;
          rd_n    = 1'b0;
          ack_n   = 1'b1;
          err_n   = 1'b0;
          rdata_n = we_r ? {DATA_W{1'b0}} : IO_RDATA[int'(idx_r)*DATA_W +: DATA_W];
        end
`ifdef OTTER_IOBUS_TIMEOUT_EN
        else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_n = RESP;
          sel_n   = {NUM_PORTS{1'b0}};
          wr_n    = 1'b0;
          rd_n    = 1'b0;
          ack_n   = 1'b1;
          err_n   = 1'b1;
          rdata_n = DATA_W'(ERR_RDATA);
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
`else
        else begin
          state_n = ACCESS;
        end
`endif
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        sel_n   = {NUM_PORTS{1'b0}};
        wr_n    = 1'b0;
        rd_n    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= IDLE;
      we_r    <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      sel_r   <= {NUM_PORTS{1'b0}};
      wr_r    <= 1'b0;
      rd_r    <= 1'b0;
      addr_r  <= {SPAN_LOG2{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      rdata_r <= {DATA_W{1'b0}};
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
`ifdef OTTER_IOBUS_TIMEOUT_EN
      cnt_r   <= {CNT_W{1'b0}};
`endif
    end else begin
      state_r <= state_n;
      we_r    <= we_n;
      idx_r   <= idx_n;
      sel_r   <= sel_n;
      wr_r    <= wr_n;
      rd_r    <= rd_n;
      addr_r  <= addr_n;
      wdata_r <= wdata_n;
      rdata_r <= rdata_n;
      ack_r   <= ack_n;
      err_r   <= err_n;
      busy_r  <= (state_n != IDLE);
`ifdef OTTER_IOBUS_TIMEOUT_EN
      cnt_r   <= cnt_n;
`endif
    end
  end

  assign CPU_RDATA = rdata_r;
  assign CPU_ACK   = ack_r;
  assign CPU_ERR   = err_r;
  assign CPU_BUSY  = busy_r;
  assign IO_SEL    = sel_r;
  assign IO_WR     = wr_r;
  assign IO_RD     = rd_r;
  assign IO_ADDR   = addr_r;
  assign IO_WDATA  = wdata_r;

endmodule

// File: tb/tb_otter_iobus_bridge.sv
// Directed self-checking bench for otter_iobus_bridge; timeout expectations follow
// whether OTTER_IOBUS_TIMEOUT_EN is defined for the build.
module tb_otter_iobus_bridge;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         CPU_REQ = 1'b0;
  logic         CPU_WE = 1'b0;
  logic [31:0]  CPU_ADDR = 32'h0;
  logic [31:0]  CPU_WDATA = 32'h0;
  logic [31:0]  CPU_RDATA;
  logic         CPU_ACK, CPU_ERR, CPU_BUSY;
  logic [3:0]   IO_SEL;
  logic         IO_WR, IO_RD;
  logic [7:0]   IO_ADDR;
  logic [31:0]  IO_WDATA;
  logic [127:0] IO_RDATA = 128'h0;
  logic [3:0]   IO_RDY = 4'b0000;

  int n_checks = 0;
  int n_fail   = 0;

  otter_iobus_bridge #(
    .NUM_PORTS(4), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h1100_0000),
    .SPAN_LOG2(8), .TIMEOUT_CYC(16)
  ) dut (
    .CLK(CLK), .RST(RST), .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR),
    .CPU_WDATA(CPU_WDATA), .CPU_RDATA(CPU_RDATA), .CPU_ACK(CPU_ACK), .CPU_ERR(CPU_ERR),
    .CPU_BUSY(CPU_BUSY), .IO_SEL(IO_SEL), .IO_WR(IO_WR), .IO_RD(IO_RD), .IO_ADDR(IO_ADDR),
    .IO_WDATA(IO_WDATA), .IO_RDATA(IO_RDATA), .IO_RDY(IO_RDY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    tick();
    n_checks++; if ({CPU_RDATA, CPU_ACK, CPU_ERR, IO_SEL, IO_WR, IO_RD, IO_ADDR, IO_WDATA} !== 80'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", {CPU_RDATA, CPU_ACK, CPU_ERR, IO_SEL, IO_WR, IO_RD, IO_ADDR, IO_WDATA}); end
    n_checks++; if (CPU_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", CPU_BUSY); end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_write_port2();
    IO_RDY = 4'b0100;
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 32'h1100_0204; CPU_WDATA = 32'hA5A5_0001;
    tick();
    CPU_REQ = 1'b0;
    n_checks++; if (IO_SEL !== 4'b0100) begin n_fail++; $display("FAIL wr_sel got=%b exp=0100", IO_SEL); end
    n_checks++; if ({IO_WR, IO_RD} !== 2'b10) begin n_fail++; $display("FAIL wr_strobes got=%b exp=10", {IO_WR, IO_RD}); end
    n_checks++; if (IO_ADDR !== 8'h04) begin n_fail++; $display("FAIL wr_addr got=%h exp=04", IO_ADDR); end
    n_checks++; if (IO_WDATA !== 32'hA5A5_0001) begin n_fail++; $display("FAIL wr_wdata got=%h exp=a5a50001", IO_WDATA); end
    n_checks++; if ({CPU_BUSY, CPU_ACK} !== 2'b10) begin n_fail++; $display("FAIL wr_access_busy_ack got=%b exp=10", {CPU_BUSY, CPU_ACK}); end
    tick();
    n_checks++; if ({CPU_ACK, CPU_ERR} !== 2'b10) begin n_fail++; $display("FAIL wr_ack_err got=%b exp=10", {CPU_ACK, CPU_ERR}); end
    n_checks++; if ({IO_SEL, IO_WR} !== 5'b00000) begin n_fail++; $display("FAIL wr_drop got=%b exp=00000", {IO_SEL, IO_WR}); end
    IO_RDY = 4'b0000;
    tick();
    n_checks++; if ({CPU_ACK, CPU_BUSY} !== 2'b00) begin n_fail++; $display("FAIL wr_idle got=%b exp=00", {CPU_ACK, CPU_BUSY}); end
  endtask

  task automatic test_unmapped(input logic [31:0] addr);
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = addr;
    tick();
    CPU_REQ = 1'b0;
    n_checks++; if ({CPU_ACK, CPU_ERR, CPU_BUSY} !== 3'b111) begin n_fail++; $display("FAIL unmap_ack_err_busy addr=%h got=%b exp=111", addr, {CPU_ACK, CPU_ERR, CPU_BUSY}); end
    n_checks++; if ({IO_SEL, IO_RD, IO_WR} !== 6'b000000) begin n_fail++; $display("FAIL unmap_io addr=%h got=%b exp=000000", addr, {IO_SEL, IO_RD, IO_WR}); end
    n_checks++; if (CPU_RDATA !== 32'h0) begin n_fail++; $display("FAIL unmap_rdata addr=%h got=%h exp=0", addr, CPU_RDATA); end
    tick();
    n_checks++; if ({CPU_ACK, CPU_BUSY, IO_SEL} !== 6'b000000) begin n_fail++; $display("FAIL unmap_idle addr=%h got=%b exp=000000", addr, {CPU_ACK, CPU_BUSY, IO_SEL}); end
  endtask

  task automatic test_read_delayed();
    int rd_cycles;
    int early_acks;
    rd_cycles = 0;
    early_acks = 0;
    IO_RDATA = {32'h4444_0003, 32'h3333_0002, 32'h0000_BEEF, 32'h1111_0000};
    IO_RDY = 4'b1101;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 32'h1100_0110;
    tick();
    CPU_REQ = 1'b0;
    n_checks++; if ({IO_SEL, IO_ADDR} !== {4'b0010, 8'h10}) begin n_fail++; $display("FAIL rd_sel_addr got=%b/%h exp=0010/10", IO_SEL, IO_ADDR); end
    for (int i = 1; i <= 5; i++) begin
      if (IO_RD === 1'b1 && IO_SEL === 4'b0010) rd_cycles++;
      if (CPU_ACK !== 1'b0) early_acks++;
      if (i == 3) begin
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 32'h1100_0000;
      end else begin
        CPU_REQ = 1'b0;
      end
      tick();
    end
    IO_RDY = 4'b0010;
    if (IO_RD === 1'b1 && IO_SEL === 4'b0010) rd_cycles++;
    if (CPU_ACK !== 1'b0) early_acks++;
    tick();
    n_checks++; if (rd_cycles != 6) begin n_fail++; $display("FAIL rd_hold_cycles got=%0d exp=6", rd_cycles); end
    n_checks++; if (early_acks != 0) begin n_fail++; $display("FAIL rd_early_ack got=%0d exp=0", early_acks); end
    n_checks++; if ({CPU_ACK, CPU_ERR, IO_RD} !== 3'b100) begin n_fail++; $display("FAIL rd_ack_err_rd got=%b exp=100", {CPU_ACK, CPU_ERR, IO_RD}); end
    n_checks++; if (CPU_RDATA !== 32'h0000_BEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=0000beef", CPU_RDATA); end
    IO_RDY = 4'b0000;
    tick();
    n_checks++; if ({CPU_ACK, CPU_BUSY, IO_SEL, IO_WR} !== 7'b0000000) begin n_fail++; $display("FAIL rd_midreq_ignored got=%b exp=0000000", {CPU_ACK, CPU_BUSY, IO_SEL, IO_WR}); end
    n_checks++; if (CPU_RDATA !== 32'h0000_BEEF) begin n_fail++; $display("FAIL rd_data_hold got=%h exp=0000beef", CPU_RDATA); end
  endtask

  task automatic test_timeout();
    int acc_cycles;
    int acks;
    acc_cycles = 0;
    acks = 0;
    IO_RDY = 4'b0000;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 32'h1100_0000;
    tick();
    CPU_REQ = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (CPU_ACK === 1'b1) begin
        acks++;
        break;
      end
      if (IO_RD === 1'b1) acc_cycles++;
      tick();
    end
`ifdef OTTER_IOBUS_TIMEOUT_EN
    n_checks++; if (acks != 1) begin n_fail++; $display("FAIL to_ack_seen got=%0d exp=1", acks); end
    n_checks++; if (acc_cycles != 16) begin n_fail++; $display("FAIL to_access_cycles got=%0d exp=16", acc_cycles); end
    n_checks++; if ({CPU_ERR, IO_RD, IO_SEL} !== 6'b100000) begin n_fail++; $display("FAIL to_err_drop got=%b exp=100000", {CPU_ERR, IO_RD, IO_SEL}); end
    n_checks++; if (CPU_RDATA !== 32'h0) begin n_fail++; $display("FAIL to_rdata got=%h exp=0", CPU_RDATA); end
    tick();
    n_checks++; if ({CPU_ACK, CPU_BUSY} !== 2'b00) begin n_fail++; $display("FAIL to_idle got=%b exp=00", {CPU_ACK, CPU_BUSY}); end
`else
    n_checks++; if (acks != 0) begin n_fail++; $display("FAIL hang_no_ack got=%0d exp=0", acks); end
    n_checks++; if ({CPU_BUSY, IO_RD, IO_SEL} !== 6'b110001) begin n_fail++; $display("FAIL hang_held got=%b exp=110001", {CPU_BUSY, IO_RD, IO_SEL}); end
    RST = 1'b0;
    tick();
    RST = 1'b1;
    tick();
`endif
  endtask

  task automatic test_reset_mid_access();
    int acks;
    acks = 0;
    IO_RDATA = {32'hCAFE_F00D, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    IO_RDY = 4'b0000;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 32'h1100_0308;
    tick();
    CPU_REQ = 1'b0;
    n_checks++; if ({IO_SEL, IO_RD} !== 5'b10001) begin n_fail++; $display("FAIL rst_mid_sel got=%b exp=10001", {IO_SEL, IO_RD}); end
    RST = 1'b0;
    IO_RDY = 4'b1000;
    tick();
    RST = 1'b1;
    n_checks++; if ({IO_SEL, IO_RD, CPU_BUSY, CPU_ACK} !== 7'b0000000) begin n_fail++; $display("FAIL rst_mid_drop got=%b exp=0000000", {IO_SEL, IO_RD, CPU_BUSY, CPU_ACK}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (CPU_ACK !== 1'b0) acks++;
    end
    n_checks++; if (acks != 0) begin n_fail++; $display("FAIL rst_mid_no_ack got=%0d exp=0", acks); end
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 32'h1100_0308;
    tick();
    CPU_REQ = 1'b0;
    tick();
    n_checks++; if ({CPU_ACK, CPU_ERR} !== 2'b10) begin n_fail++; $display("FAIL rst_after_ack got=%b exp=10", {CPU_ACK, CPU_ERR}); end
    n_checks++; if (CPU_RDATA !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rst_after_data got=%h exp=cafef00d", CPU_RDATA); end
    IO_RDY = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    IO_RDY = 4'b0011;
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 32'h1100_0000; CPU_WDATA = 32'h0000_0011;
    tick();
    n_checks++; if (IO_SEL !== 4'b0001) begin n_fail++; $display("FAIL b2b_first_sel got=%b exp=0001", IO_SEL); end
    tick();
    n_checks++; if ({CPU_ACK, CPU_ERR} !== 2'b10) begin n_fail++; $display("FAIL b2b_first_ack got=%b exp=10", {CPU_ACK, CPU_ERR}); end
    CPU_ADDR = 32'h1100_0108; CPU_WDATA = 32'h0000_0022;
    tick();
    n_checks++; if ({CPU_BUSY, CPU_ACK, IO_SEL} !== 6'b000000) begin n_fail++; $display("FAIL b2b_gap got=%b exp=000000", {CPU_BUSY, CPU_ACK, IO_SEL}); end
    tick();
    CPU_REQ = 1'b0;
    n_checks++; if ({IO_SEL, IO_ADDR, IO_WDATA} !== {4'b0010, 8'h08, 32'h0000_0022}) begin n_fail++; $display("FAIL b2b_second got=%b/%h/%h exp=0010/08/00000022", IO_SEL, IO_ADDR, IO_WDATA); end
    tick();
    n_checks++; if ({CPU_ACK, CPU_ERR} !== 2'b10) begin n_fail++; $display("FAIL b2b_second_ack got=%b exp=10", {CPU_ACK, CPU_ERR}); end
    IO_RDY = 4'b0000;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_port2();
    test_unmapped(32'h1100_0400);
    test_unmapped(32'h10FF_FFFC);
    test_read_delayed();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
